// File: rtl/err_inj_rng_arbiter_pkg.sv
// Shared constants and types for the error-injection random source:
// LFSR geometry, feedback taps, lockup word and the sequencer state encoding.
package err_inj_pkg;

  localparam int LFSR_W = 32;

  // XNOR feedback taps; with XNOR feedback the all-ones word is the lockup state
  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2
  } err_inj_state_t;

endpackage

// File: rtl/err_inj_rng_arbiter_lfsr.sv
// 32-bit XNOR Fibonacci LFSR with seed load and step enable.
// A seed equal to the lockup word is replaced by zero so the register can never stick.
module err_inj_lfsr32
  import err_inj_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~^{s[TAP_A], s[TAP_B], s[TAP_C], s[TAP_D]}};
  endfunction

  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == LFSR_LOCKUP) ? '0 : s;
  endfunction

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed_fix(seed);
    end else if (adv) begin
      q_d = lfsr_step(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/err_inj_rng_arbiter.sv
// Round-robin arbiter sharing one LFSR among NUM_REQ error-insertion lanes.
// Each grant hands out the current random word and an inject flag (word < threshold).
module err_inj_rng_arbiter
  import err_inj_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  CNT_W   = 16,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_enable,
  input  logic               cfg_seed_load,
  input  logic [LFSR_W-1:0]  cfg_seed,
  input  logic [LFSR_W-1:0]  cfg_threshold,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [LFSR_W-1:0]  rnd_data,
  output logic [IDX_W-1:0]   rnd_lane,
  output logic               inject,
  output logic [CNT_W-1:0]   err_count,
  output logic               busy
);

  err_inj_state_t     state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               vld_q;
  logic [LFSR_W-1:0]  data_q;
  logic [IDX_W-1:0]   lane_q;
  logic               inj_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic [LFSR_W-1:0]  lfsr_q;
  logic               lfsr_load;
  logic               grant;
  logic               hit;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   rr_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Search upward from rr_ptr with wrap; first set request wins
  always_comb begin
    logic [IDX_W:0] k;
    win_found = 1'b0;
    win_idx   = '0;
    k         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (k >= (IDX_W+1)'(NUM_REQ)) begin
        k = k - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && req[k[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = k[IDX_W-1:0];
      end
    end
  end

  assign rr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Seed load and a dropped enable both take priority over handing out a word
  assign grant     = (state_q == ST_RUN) && cfg_enable && !cfg_seed_load && win_found;
  assign hit       = (lfsr_q < cfg_threshold);
  assign lfsr_load = (state_q == ST_SEED);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SEED) begin
      cnt_d = '0;
    end else if (grant && hit) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  err_inj_lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (cfg_seed),
    .adv  (grant),
    .q    (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      lane_q   <= '0;
      inj_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      gnt_q <= '0;
      vld_q <= 1'b0;
      inj_q <= 1'b0;
      cnt_q <= cnt_d;

      case (state_q)
        ST_IDLE: begin
          if (cfg_seed_load) begin
            state_q <= ST_SEED;
          end else if (cfg_enable) begin
            state_q <= ST_RUN;
          end
        end
        ST_SEED: begin
          state_q <= cfg_enable ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (cfg_seed_load) begin
            state_q <= ST_SEED;
          end else if (!cfg_enable) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Word is the pre-advance LFSR value; the LFSR steps on this same edge
      if (grant) begin
        gnt_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
        vld_q    <= 1'b1;
        data_q   <= lfsr_q;
        lane_q   <= win_idx;
        inj_q    <= hit;
        rr_ptr_q <= rr_next;
      end
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = vld_q;
  assign rnd_data  = data_q;
  assign rnd_lane  = lane_q;
  assign inject    = inj_q;
  assign err_count = cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_err_inj_rng_arbiter.sv
// Directed bench for err_inj_rng_arbiter with hand-computed LFSR words,
// grant order, inject decisions and counter saturation.
module tb_err_inj_rng_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic        cfg_seed_load;
  logic [31:0] cfg_seed;
  logic [31:0] cfg_threshold;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [31:0] rnd_data;
  logic [1:0]  rnd_lane;
  logic        inject;
  logic [15:0] err_count;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  err_inj_rng_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_enable    (cfg_enable),
    .cfg_seed_load (cfg_seed_load),
    .cfg_seed      (cfg_seed),
    .cfg_threshold (cfg_threshold),
    .req           (req),
    .gnt           (gnt),
    .rnd_valid     (rnd_valid),
    .rnd_data      (rnd_data),
    .rnd_lane      (rnd_lane),
    .inject        (inject),
    .err_count     (err_count),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample/drive 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    cfg_enable    = 1'b0;
    cfg_seed_load = 1'b0;
    cfg_seed      = '0;
    cfg_threshold = '0;
    req           = '0;
    step();
    rst = 1'b0;
  endtask

  logic [31:0] w_exp [5] = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd9};
  logic [3:0]  g_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0]  l_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic        i_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int inj_miss;

    // Reset state
    do_reset();
    step();
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_vld",   32'(rnd_valid), 32'h0);
    chk("rst_data",  rnd_data, 32'h0);
    chk("rst_lane",  32'(rnd_lane), 32'h0);
    chk("rst_inj",   32'(inject), 32'h0);
    chk("rst_cnt",   32'(err_count), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);

    // 1: single lane, LFSR sequence from zero
    cfg_enable = 1'b1;
    req        = 4'b0001;
    step();
    chk("t1_run_nognt", 32'(gnt), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_gnt",  32'(gnt), 32'h1);
      chk("t1_vld",  32'(rnd_valid), 32'h1);
      chk("t1_data", rnd_data, w_exp[i]);
      chk("t1_inj",  32'(inject), 32'h0);
    end
    chk("t1_cnt", 32'(err_count), 32'h0);

    // 2: all lanes requesting, round-robin order
    do_reset();
    cfg_enable = 1'b1;
    req        = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_gnt",  32'(gnt), 32'(g_exp[i]));
      chk("t2_lane", 32'(rnd_lane), 32'(l_exp[i]));
      chk("t2_data", rnd_data, w_exp[i]);
    end

    // 3: threshold compare
    do_reset();
    cfg_enable    = 1'b1;
    cfg_threshold = 32'd3;
    req           = 4'b0001;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_data", rnd_data, w_exp[i]);
      chk("t3_inj",  32'(inject), 32'(i_exp[i]));
    end
    chk("t3_cnt", 32'(err_count), 32'd3);

    // 4: reseed with the lockup word while running
    do_reset();
    cfg_enable    = 1'b1;
    cfg_threshold = 32'hFFFF_FFFF;
    req           = 4'b0001;
    step();
    step();
    step();
    chk("t4_pre_data", rnd_data, 32'd1);
    chk("t4_pre_cnt",  32'(err_count), 32'd2);
    cfg_seed      = 32'hFFFF_FFFF;
    cfg_seed_load = 1'b1;
    step();
    chk("t4_ld_gnt",  32'(gnt), 32'h0);
    chk("t4_ld_busy", 32'(busy), 32'h1);
    cfg_seed_load = 1'b0;
    step();
    chk("t4_seed_gnt", 32'(gnt), 32'h0);
    chk("t4_seed_cnt", 32'(err_count), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_gnt",  32'(gnt), 32'h1);
      chk("t4_data", rnd_data, w_exp[i]);
    end
    chk("t4_cnt", 32'(err_count), 32'd3);

    // 5: pause and resume keeps LFSR and rr_ptr
    do_reset();
    cfg_enable = 1'b1;
    req        = 4'b1111;
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t5_gnt",  32'(gnt), 32'(g_exp[i]));
      chk("t5_data", rnd_data, w_exp[i]);
    end
    cfg_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_off_gnt", 32'(gnt), 32'h0);
      chk("t5_off_vld", 32'(rnd_valid), 32'h0);
    end
    chk("t5_off_busy", 32'(busy), 32'h0);
    cfg_enable = 1'b1;
    step();
    chk("t5_re_gnt", 32'(gnt), 32'h0);
    for (int i = 2; i < 4; i++) begin
      step();
      chk("t5_gnt",  32'(gnt), 32'(g_exp[i]));
      chk("t5_lane", 32'(rnd_lane), 32'(l_exp[i]));
      chk("t5_data", rnd_data, w_exp[i]);
    end

    // 6: inject always, counter saturation, then reset mid-burst
    do_reset();
    cfg_enable    = 1'b1;
    cfg_threshold = 32'hFFFF_FFFF;
    req           = 4'b0001;
    step();
    inj_miss = 0;
    for (int i = 0; i < 70000; i++) begin
      step();
      if (!(inject === 1'b1 && rnd_valid === 1'b1)) inj_miss++;
      if (i == 65533) chk("t6_cnt_pre", 32'(err_count), 32'h0000_FFFE);
    end
    chk("t6_inj_miss", 32'(inj_miss), 32'd0);
    chk("t6_cnt_sat",  32'(err_count), 32'h0000_FFFF);
    chk("t6_gnt",      32'(gnt), 32'h1);
    rst = 1'b1;
    step();
    chk("t6_rst_gnt",  32'(gnt), 32'h0);
    chk("t6_rst_vld",  32'(rnd_valid), 32'h0);
    chk("t6_rst_data", rnd_data, 32'h0);
    chk("t6_rst_lane", 32'(rnd_lane), 32'h0);
    chk("t6_rst_inj",  32'(inject), 32'h0);
    chk("t6_rst_cnt",  32'(err_count), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
